vend_credit_ctrl: RTL
=====================

// Module: vend_credit_ctrl
// PURPOSE
//  Parametrised coin-credit vending controller; successor to the fixed 4-credit machine.
//  Takes three one-hot-ish coin strobes (circle/triangle/pentagon) of configurable value.
//  Keeps the residual credit modulo PRICE and queues one vend per PRICE reached.
//  Issues the queued vends as spaced single-cycle drop pulses.
//  Sits between the debounced coin sensors and the dispenser actuator.
// PARAMETERS
//  PRICE         4  credits per vend; >=2
//  CIRCLE_VAL    1  credit value of circle coin; 1..15
//  TRIANGLE_VAL  3  credit value of triangle coin; 1..15
//  PENTAGON_VAL  5  credit value of pentagon coin; 1..15
//  CREDIT_W      2  width of credit output; 2**CREDIT_W >= PRICE
//  PEND_W        3  width of pending-vend counter
// PORTS
//  clock     in   1         system clock; all state changes on posedge
//  reset     in   1         synchronous, active-high
//  circle    in   1         coin strobe, level, value CIRCLE_VAL
//  triangle  in   1         coin strobe, level, value TRIANGLE_VAL
//  pentagon  in   1         coin strobe, level, value PENTAGON_VAL
//  credit    out  CREDIT_W  residual credit, always < PRICE
//  drop      out  1         one-cycle dispense pulse, one per vend
//  pending   out  PEND_W    vends owed but not yet dropped
//  jam       out  1         sticky: pending counter saturated, vend(s) lost
// BEHAVIOUR
//  - Reset: credit=0, drop=0, pending=0, jam=0, FSM=ARMED. Reset overrides everything,
//    mid-wait included; owed vends are discarded.
//  - Coin FSM, 2 states:
//    ARMED: any strobe high at the edge -> accept one coin, go WAIT.
//    WAIT: any strobe high -> stay WAIT, nothing accepted; all low -> ARMED.
//  - A held or re-asserted strobe counts only once until all strobes have been low
//    for >=1 edge.
//  - Simultaneous strobes: exactly one coin accepted; priority circle > triangle > pentagon.
//  - Accept arithmetic: sum = credit + VAL (width CREDIT_W+4).
//    credit <= sum % PRICE; vends = sum / PRICE (may be 0, 1 or more).
//    Updates at the accepting edge; visible the next cycle.
//  - Drop engine: drop is registered.
//    At an edge where drop==0 and pending>0 (pre-update): drop<=1, pending decremented.
//    Otherwise drop<=0, so successive pulses are separated by >=1 low cycle.
//  - Pending update per edge: pending <= pending + vends - (drop issued ? 1 : 0).
//    Increment and decrement in the same edge both apply.
//  - Saturation: if the result exceeds 2**PEND_W-1, pending <= 2**PEND_W-1 and jam <= 1.
//    jam stays 1 until reset.
//  - Latency: a coin completing a vend at edge t gives pending=1 in cycle t+1, drop=1 in
//    cycle t+2 (if no earlier vends are queued).
//  - The credit output never reads PRICE or above; no wrap beyond modulo arithmetic.
// CONFIGURATION
//  - VEND_REFUND_EN defined: adds input refund (1b) and outputs refund_valid (1b) and
//    refund_val (CREDIT_W).
//    refund high at an edge in ARMED with no strobe: refund_val <= credit,
//    refund_valid <= 1 for one cycle, credit <= 0. Pending vends are unaffected.
//    If refund and a strobe are high together, the coin wins and refund is ignored.
//    In WAIT, refund is ignored.
//  - VEND_REFUND_EN undefined: ports absent; credit is only ever consumed by vends.
// TESTING (defaults PRICE=4, values 1/3/5)
//  - Reset, then circle held 3 cycles then released -> credit=1 once; pending=0;
//    drop never high.
//  - credit=1, pentagon pulse -> credit=2, pending=1, then a single drop pulse, pending=0.
//  - credit=3, pentagon -> sum=8: credit=0, pending=2; drops in cycles t+2 and t+4;
//    drop low in t+3.
//  - circle+triangle+pentagon together from credit=0 -> circle only: credit=1, pending=0.
//  - PEND_W=1, credit=3, pentagon -> pending=1, jam=1 and sticky; reset clears all
//    outputs to 0.
//  - VEND_REFUND_EN, credit=3, refund -> refund_valid=1 for one cycle, refund_val=3,
//    credit=0.

Source files
------------

// File: rtl/vend_credit_ctrl_if.sv
// Coin-sensor / dispenser bundle for vend_credit_ctrl; refund signals exist only with VEND_REFUND_EN.
interface vend_credit_ctrl_if #(
    parameter int CREDIT_W = 2,
    parameter int PEND_W   = 3
);
    logic                circle;
    logic                triangle;
    logic                pentagon;
    logic [CREDIT_W-1:0] credit;
    logic                drop;
    logic [PEND_W-1:0]   pending;
    logic                jam;
`ifdef VEND_REFUND_EN
    logic                refund;
    logic                refund_valid;
    logic [CREDIT_W-1:0] refund_val;
`endif

    modport master (
        output circle, triangle, pentagon,
        input  credit, drop, pending, jam
`ifdef VEND_REFUND_EN
        ,
        output refund,
        input  refund_valid, refund_val
`endif
    );

    modport slave (
        input  circle, triangle, pentagon,
        output credit, drop, pending, jam
`ifdef VEND_REFUND_EN
        ,
        input  refund,
        output refund_valid, refund_val
`endif
    );
endinterface

// File: rtl/vend_credit_ctrl.sv
// Coin-credit vending controller: one coin per strobe episode, queued vends, spaced drop pulses.
// Latency: credit/pending visible 1 cycle after accepting edge, drop 1 cycle later; no backpressure.
// VEND_REFUND_EN adds a refund request that returns the residual credit while armed.
module vend_credit_ctrl #(
    parameter int PRICE        = 4,
    parameter int CIRCLE_VAL   = 1,
    parameter int TRIANGLE_VAL = 3,
    parameter int PENTAGON_VAL = 5,
    parameter int CREDIT_W     = 2,
    parameter int PEND_W       = 3
) (
    input  logic              clock,
    input  logic              reset,
    vend_credit_ctrl_if.slave bus
);
    localparam int SUM_W = CREDIT_W + 4;
    localparam int ACC_W = PEND_W + SUM_W + 1;
    localparam logic [SUM_W-1:0] PRICE_S  = SUM_W'(PRICE);
    localparam logic [ACC_W-1:0] PEND_MAX = ACC_W'((2 ** PEND_W) - 1);

    typedef enum logic {ST_ARMED, ST_WAIT} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CREDIT_W-1:0] credit_q;
    logic                drop_q;
    logic [PEND_W-1:0]   pend_q;
    logic                jam_q;

    logic                any_coin;
    logic                accept;
    logic [SUM_W-1:0]    coin_val;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    vends;
    logic                drop_issue;
    logic [ACC_W-1:0]    pend_acc;
`ifdef VEND_REFUND_EN
    logic                refund_take;
    logic                refund_valid_q;
    logic [CREDIT_W-1:0] refund_val_q;
`endif

    assign any_coin = bus.circle | bus.triangle | bus.pentagon;

    always_ff @(posedge clock) begin
        if (reset) state <= ST_ARMED;
        else       state <= state_nxt;
    end

    // A coin is counted once; all strobes must drop for an edge before the next one
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARMED: if (any_coin)  state_nxt = ST_WAIT;
            ST_WAIT:  if (!any_coin) state_nxt = ST_ARMED;
            default:  state_nxt = ST_ARMED;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        coin_val = '0;
`ifdef VEND_REFUND_EN
        refund_take = 1'b0;
`endif
        if (state == ST_ARMED) begin
            if (any_coin) begin
                accept = 1'b1;
                if (bus.circle)        coin_val = SUM_W'(CIRCLE_VAL);
                else if (bus.triangle) coin_val = SUM_W'(TRIANGLE_VAL);
                else                   coin_val = SUM_W'(PENTAGON_VAL);
            end
`ifdef VEND_REFUND_EN
            else begin
                refund_take = bus.refund;
            end
`endif
        end
    end

    assign sum        = SUM_W'(credit_q) + coin_val;
    assign vends      = accept ? (sum / PRICE_S) : '0;
    assign drop_issue = !drop_q && (pend_q != '0);
    // Wide enough that an increment and a decrement in the same edge never wrap
    assign pend_acc   = ACC_W'(pend_q) + ACC_W'(vends) - ACC_W'(drop_issue);

    always_ff @(posedge clock) begin
        if (reset) begin
            credit_q <= '0;
            drop_q   <= 1'b0;
            pend_q   <= '0;
            jam_q    <= 1'b0;
        end else begin
            if (accept) credit_q <= CREDIT_W'(sum % PRICE_S);
`ifdef VEND_REFUND_EN
            else if (refund_take) credit_q <= '0;
`endif
            drop_q <= drop_issue;
            if (pend_acc > PEND_MAX) begin
                pend_q <= '1;
                jam_q  <= 1'b1;
            end else begin
                pend_q <= PEND_W'(pend_acc);
            end
        end
    end

    assign bus.credit  = credit_q;
    assign bus.drop    = drop_q;
    assign bus.pending = pend_q;
    assign bus.jam     = jam_q;

`ifdef VEND_REFUND_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            refund_valid_q <= 1'b0;
            refund_val_q   <= '0;
        end else begin
            refund_valid_q <= refund_take;
            if (refund_take) refund_val_q <= credit_q;
        end
    end

    assign bus.refund_valid = refund_valid_q;
    assign bus.refund_val   = refund_val_q;
`endif
endmodule
